// File: rtl/cam_pkg.sv
// ============================================================================
// Module  : cam_pkg
// Purpose : Shared types and helpers for the CAM search controller.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package cam_pkg;

   localparam int CAM_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      RESP   = 2'd2
   } state_e;

   typedef struct packed {
      logic                  write;
      logic [CAM_DATA_W-1:0] data;
   } cam_req_t;

   function automatic int cam_idxw(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/cam_prio_enc.sv
// ============================================================================
// Module  : cam_prio_enc
// Purpose : Combinational lowest-set-bit priority encoder -> {hit, index}.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module cam_prio_enc
   import cam_pkg::*;
#(
   parameter  int DEPTH = 8,
   localparam int IDXW  = cam_idxw(DEPTH)
) (
   input  logic [DEPTH-1:0] vec_i,
   output logic             hit_o,
   output logic [IDXW-1:0]  index_o
);

   // Scan from the top down so the lowest set bit is the last assignment.
   always_comb begin
      hit_o   = |vec_i;
      index_o = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (vec_i[i]) index_o = IDXW'(i);
      end
   end

endmodule

`default_nettype wire

// File: rtl/cam_search_ctrl.sv
// ============================================================================
// Module  : cam_search_ctrl
// Purpose : CAM row-interface initiator: write/search requests, broadcast
//           strobes, lowest-index match resolution and response handshake.
//           Define CAM_MULTIHIT_EN to add resp_multi_o / resp_count_o.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module cam_search_ctrl
   import cam_pkg::*;
#(
   parameter  int WIDTH = CAM_DATA_W,
   parameter  int DEPTH = 8,
   localparam int IDXW  = cam_idxw(DEPTH)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   req_valid_i,
   output logic                   req_ready_o,
   input  logic                   req_write_i,
   input  logic [WIDTH-1:0]       req_data_i,
   output logic                   resp_valid_o,
   input  logic                   resp_ready_i,
   output logic                   resp_hit_o,
   output logic [IDXW-1:0]        resp_index_o,
   output logic [WIDTH-1:0]       resp_data_o,
`ifdef CAM_MULTIHIT_EN
   output logic                   resp_multi_o,
   output logic [IDXW:0]          resp_count_o,
`endif
   output logic                   full_o,
   output logic [WIDTH-1:0]       row_data_o,
   output logic [DEPTH-1:0]       row_write_enable_o,
   output logic                   row_search_enable_o,
   output logic [WIDTH-1:0]       row_search_data_o,
   input  logic [DEPTH-1:0]       row_match_i,
   input  logic [DEPTH-1:0]       row_valid_i,
   input  logic [DEPTH*WIDTH-1:0] row_data_i
);

   localparam logic [IDXW:0] FULL_CNT = (IDXW+1)'(DEPTH);

   state_e           state_q,  state_d;
   logic [IDXW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [IDXW:0]    count_q,  count_d;
   logic [WIDTH-1:0] wdata_q,  wdata_d;
   logic [WIDTH-1:0] key_q,    key_d;
   logic [DEPTH-1:0] wen_q,    wen_d;
   logic             hit_q,    hit_d;
   logic [IDXW-1:0]  index_q,  index_d;
   logic [WIDTH-1:0] rdata_q,  rdata_d;
`ifdef CAM_MULTIHIT_EN
   logic             multi_q,  multi_d;
   logic [IDXW:0]    cnt_q,    cnt_d;
   logic [IDXW:0]    qual_cnt;
`endif

   cam_req_t         req;
   logic [DEPTH-1:0] qual;
   logic             enc_hit;
   logic [IDXW-1:0]  enc_index;
   logic [WIDTH-1:0] row_word [DEPTH];

   assign req  = '{write: req_write_i, data: CAM_DATA_W'(req_data_i)};
   // Only rows that have been written since reset may report a match.
   assign qual = row_match_i & row_valid_i;

   for (genvar r = 0; r < DEPTH; r++) begin : g_row_word
      assign row_word[r] = row_data_i[r*WIDTH +: WIDTH];
   end

   cam_prio_enc #(.DEPTH(DEPTH)) u_prio_enc (
      .vec_i   (qual),
      .hit_o   (enc_hit),
      .index_o (enc_index)
   );

`ifdef CAM_MULTIHIT_EN
   always_comb begin
      qual_cnt = '0;
      for (int i = 0; i < DEPTH; i++) begin
         qual_cnt = qual_cnt + (IDXW+1)'(qual[i]);
      end
   end
`endif

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      wdata_d  = wdata_q;
      key_d    = key_q;
      wen_d    = '0;
      hit_d    = hit_q;
      index_d  = index_q;
      rdata_d  = rdata_q;
`ifdef CAM_MULTIHIT_EN
      multi_d  = multi_q;
      cnt_d    = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (req_valid_i) begin
               if (req.write) begin
                  wen_d    = {{(DEPTH-1){1'b0}}, 1'b1} << wr_ptr_q;
                  wdata_d  = WIDTH'(req.data);
                  wr_ptr_d = wr_ptr_q + 1'b1;
                  if (count_q != FULL_CNT) count_d = count_q + 1'b1;
               end else begin
                  key_d   = WIDTH'(req.data);
                  state_d = SEARCH;
               end
            end
         end
         SEARCH: begin
            hit_d   = enc_hit;
            index_d = enc_index;
            rdata_d = enc_hit ? row_word[enc_index] : '0;
`ifdef CAM_MULTIHIT_EN
            multi_d = (qual_cnt > (IDXW+1)'(1));
            cnt_d   = qual_cnt;
`endif
            state_d = RESP;
         end
         RESP: begin
            if (resp_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         count_q  <= '0;
         wdata_q  <= '0;
         key_q    <= '0;
         wen_q    <= '0;
         hit_q    <= 1'b0;
         index_q  <= '0;
         rdata_q  <= '0;
`ifdef CAM_MULTIHIT_EN
         multi_q  <= 1'b0;
         cnt_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         wdata_q  <= wdata_d;
         key_q    <= key_d;
         wen_q    <= wen_d;
         hit_q    <= hit_d;
         index_q  <= index_d;
         rdata_q  <= rdata_d;
`ifdef CAM_MULTIHIT_EN
         multi_q  <= multi_d;
         cnt_q    <= cnt_d;
`endif
      end
   end

   assign req_ready_o         = (state_q == IDLE);
   assign resp_valid_o        = (state_q == RESP);
   assign resp_hit_o          = hit_q;
   assign resp_index_o        = index_q;
   assign resp_data_o         = rdata_q;
   assign full_o              = (count_q == FULL_CNT);
   assign row_data_o          = wdata_q;
   assign row_write_enable_o  = wen_q;
   assign row_search_enable_o = (state_q == SEARCH);
   assign row_search_data_o   = key_q;
`ifdef CAM_MULTIHIT_EN
   assign resp_multi_o        = multi_q;
   assign resp_count_o        = cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cam_search_ctrl.sv
// ============================================================================
// Module  : tb_cam_search_ctrl
// Purpose : Self-checking bench for cam_search_ctrl with a behavioural row
//           array and an array-based reference model (CAM_MULTIHIT_EN aware).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cam_search_ctrl;
   localparam int W  = 32;
   localparam int D  = 8;
   localparam int IW = 3;

   logic           clk = 1'b0;
   logic           reset;
   logic           req_valid, req_write, resp_ready;
   logic [W-1:0]   req_data;
   logic           req_ready_o, resp_valid_o, resp_hit_o, full_o;
   logic [IW-1:0]  resp_index_o;
   logic [W-1:0]   resp_data_o, row_data_o, row_search_data_o;
   logic [D-1:0]   row_write_enable_o, row_match, row_valid;
   logic           row_search_enable_o;
   logic [D*W-1:0] row_data;
`ifdef CAM_MULTIHIT_EN
   logic           resp_multi_o;
   logic [IW:0]    resp_count_o;
`endif

   cam_search_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
      .clk(clk), .reset(reset),
      .req_valid_i(req_valid), .req_ready_o(req_ready_o),
      .req_write_i(req_write), .req_data_i(req_data),
      .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready),
      .resp_hit_o(resp_hit_o), .resp_index_o(resp_index_o), .resp_data_o(resp_data_o),
`ifdef CAM_MULTIHIT_EN
      .resp_multi_o(resp_multi_o), .resp_count_o(resp_count_o),
`endif
      .full_o(full_o), .row_data_o(row_data_o),
      .row_write_enable_o(row_write_enable_o),
      .row_search_enable_o(row_search_enable_o), .row_search_data_o(row_search_data_o),
      .row_match_i(row_match), .row_valid_i(row_valid), .row_data_i(row_data)
   );

   always #5 clk = ~clk;

   // Behavioural row array (the parent's role).
   logic [W-1:0] rows [D];
   logic [D-1:0] force_mask = '0;
   always @(posedge clk) begin
      if (reset) begin
         row_valid <= '0;
         for (int r = 0; r < D; r++) rows[r] <= '0;
      end else begin
         for (int r = 0; r < D; r++) begin
            if (row_write_enable_o[r]) begin
               rows[r]      <= row_data_o;
               row_valid[r] <= 1'b1;
            end
         end
      end
   end
   always_comb begin
      row_match = '0;
      row_data  = '0;
      for (int r = 0; r < D; r++) begin
         row_match[r]        = (rows[r] == row_search_data_o) | force_mask[r];
         row_data[r*W +: W]  = rows[r];
      end
   end

   // Reference model.
   logic [W-1:0] mmem [D];
   bit           mvalid [D];
   int           mptr, mcount;
   int           n_cmp = 0, n_err = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      for (int r = 0; r < D; r++) begin
         mmem[r]   = '0;
         mvalid[r] = 0;
      end
      mptr   = 0;
      mcount = 0;
   endtask

   task automatic model_search(input logic [W-1:0] key, output bit hit, output int idx,
                               output logic [W-1:0] data, output int cnt);
      hit = 0; idx = 0; data = '0; cnt = 0;
      for (int r = 0; r < D; r++) begin
         if (mvalid[r] && (mmem[r] == key || force_mask[r])) begin
            if (!hit) begin
               hit = 1; idx = r; data = mmem[r];
            end
            cnt++;
         end
      end
   endtask

   task automatic do_reset();
      reset = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
      tick(); tick();
      reset = 1'b0;
      model_clear();
   endtask

   task automatic do_write(input logic [W-1:0] d);
      chk("wr_ready", req_ready_o, 1);
      req_valid = 1'b1; req_write = 1'b1; req_data = d;
      tick();
      req_valid = 1'b0;
      chk("wr_strobe", row_write_enable_o, 64'(1) << mptr);
      chk("wr_data", row_data_o, d);
      mmem[mptr] = d; mvalid[mptr] = 1;
      mptr = (mptr + 1) % D;
      if (mcount < D) mcount++;
      chk("wr_full", full_o, (mcount == D) ? 1 : 0);
   endtask

   task automatic do_search(input logic [W-1:0] key, input int hold);
      bit           eh;
      int           ei, ec;
      logic [W-1:0] ed;
      chk("s_ready", req_ready_o, 1);
      req_valid = 1'b1; req_write = 1'b0; req_data = key;
      tick();
      req_valid = 1'b0;
      chk("s_en", row_search_enable_o, 1);
      chk("s_key", row_search_data_o, key);
      chk("s_wen0", row_write_enable_o, 0);
      chk("s_busy", req_ready_o, 0);
      model_search(key, eh, ei, ed, ec);
      tick();
      for (int h = 0; h <= hold; h++) begin
         chk("r_valid", resp_valid_o, 1);
         chk("r_hit", resp_hit_o, eh);
         chk("r_index", resp_index_o, ei);
         chk("r_data", resp_data_o, ed);
`ifdef CAM_MULTIHIT_EN
         chk("r_multi", resp_multi_o, (ec > 1) ? 1 : 0);
         chk("r_count", resp_count_o, ec);
`endif
         chk("r_busy", req_ready_o, 0);
         chk("r_sen0", row_search_enable_o, 0);
         chk("r_wen0", row_write_enable_o, 0);
         chk("r_keyhold", row_search_data_o, key);
         if (h < hold) begin
            req_valid = 1'($urandom); req_write = 1'($urandom); req_data = $urandom;
            resp_ready = 1'b0;
         end else begin
            req_valid = 1'b0; resp_ready = 1'b1;
         end
         tick();
      end
      resp_ready = 1'b0;
      chk("r_done", resp_valid_o, 0);
      chk("r_idle", req_ready_o, 1);
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      req_valid = 1'b0; req_write = 1'b0; req_data = '0; resp_ready = 1'b0;
      reset = 1'b1;
      tick(); tick();
      chk("rst_ready", req_ready_o, 1);
      chk("rst_rvalid", resp_valid_o, 0);
      chk("rst_full", full_o, 0);
      chk("rst_wen", row_write_enable_o, 0);
      chk("rst_sen", row_search_enable_o, 0);
      chk("rst_skey", row_search_data_o, 0);
      chk("rst_wdata", row_data_o, 0);
      chk("rst_hit", resp_hit_o, 0);
      chk("rst_idx", resp_index_o, 0);
      chk("rst_rdata", resp_data_o, 0);
      reset = 1'b0;
      model_clear();

      do_search(32'hA5, 0);
      chk("a5_hit", resp_hit_o, 0);

      do_write(32'h11); do_write(32'h22); do_write(32'h33);
      do_search(32'h22, 0);
      chk("k22_index", resp_index_o, 1);
      chk("k22_data", resp_data_o, 32'h22);

      do_reset();
      for (int i = 0; i <= D; i++) do_write(W'(i));
      chk("wrap_full", full_o, 1);
      do_search(32'h0, 1);
      chk("wrap_miss", resp_hit_o, 0);

      do_reset();
      begin
         logic [W-1:0] vals [D];
         vals = '{32'h1, 32'h2, 32'h5, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7};
         for (int i = 0; i < D; i++) do_write(vals[i]);
      end
      do_search(32'h5, 4);
      chk("dup_index", resp_index_o, 2);

      do_reset();
      do_write(32'h9);
      force_mask = 8'hF0;
      do_search(32'h44, 0);
      chk("unwritten_miss", resp_hit_o, 0);
      force_mask = 8'h01;
      do_search(32'h44, 0);
      force_mask = '0;

      do_write(32'h12); do_write(32'h13);
      req_valid = 1'b1; req_write = 1'b0; req_data = 32'h12;
      tick();
      req_valid = 1'b0;
      chk("pre_rst_sen", row_search_enable_o, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      model_clear();
      chk("mid_rst_rvalid", resp_valid_o, 0);
      chk("mid_rst_ready", req_ready_o, 1);
      chk("mid_rst_full", full_o, 0);
      chk("mid_rst_sen", row_search_enable_o, 0);
      do_write(32'h77);

      do_reset();
      for (int n = 0; n < 300; n++) begin
         force_mask = ($urandom_range(0, 9) == 0) ? D'($urandom) : '0;
         if ($urandom_range(0, 1) == 1)
            do_write(W'($urandom_range(0, 7)));
         else
            do_search(W'($urandom_range(0, 7)), $urandom_range(0, 3));
         if ($urandom_range(0, 60) == 0) do_reset();
      end
      force_mask = '0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
